reg_port_master: RTL
====================

# reg_port_master

Command-driven initiator for the CPU's 8×8-bit register file (the `Registers` block). It accepts write, read and dump commands over a valid/ready interface and drives the register file's write and read ports. It absorbs the file's one-cycle registered read latency and returns read data over a valid/ready response channel. It sits between the control/debug logic and the register file, and is the only agent driving the file's ports.

## Interface
Parameters:
- ADDR_W, 3, register address width
- DATA_W, 8, register data width
- NUM_REGS, 8, registers swept by DUMP (2**ADDR_W)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  2  00 NOP, 01 WRITE, 10 READ, 11 DUMP
- cmd_addr  in  ADDR_W  target register (WRITE/READ; ignored by NOP/DUMP)
- cmd_data  in  DATA_W  write data (WRITE only)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_addr  out  ADDR_W  register the response data came from
- rsp_data  out  DATA_W  read data
- rf_read_addr  out  ADDR_W  to register file read_addr
- rf_write_addr  out  ADDR_W  to register file write_addr
- rf_data_in  out  DATA_W  to register file data_in
- rf_write_enable  out  1  to register file write_enable
- rf_data_out  in  DATA_W  from register file data_out (valid one cycle after read_addr is sampled)
- busy  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, WR, RD_ADDR, RD_WAIT, RESP.
- cmd_ready = (state == IDLE); the block accepts one command at a time.
- IDLE, accept NOP: stay in IDLE; no port activity; no response.
- IDLE, accept WRITE: latch addr/data; go to WR.
- WR: rf_write_enable = 1 for exactly this one cycle, with rf_write_addr/rf_data_in = latched values; then go to IDLE. Writes generate no response.
- IDLE, accept READ: latch addr; clear the dump flag; go to RD_ADDR.
- IDLE, accept DUMP: addr register = 0; set the dump flag; go to RD_ADDR.
- RD_ADDR: rf_read_addr = addr register; the register file samples it at the end of this cycle; go to RD_WAIT.
- RD_WAIT: rf_data_out is valid; capture it into rsp_data and addr into rsp_addr at the end of the cycle; go to RESP.
- RESP: rsp_valid = 1; rsp_addr and rsp_data stay stable until the handshake.
- RESP handshake with dump flag clear, or with addr == NUM_REGS-1: go to IDLE.
- RESP handshake otherwise (dump in progress): increment addr; go to RD_ADDR.
- rf_read_addr always reflects the addr register; it is don't-care outside RD_ADDR.
- rf_write_addr/rf_data_in hold their last values; they are don't-care while rf_write_enable = 0.
- Address increment is ADDR_W bits wide; the dump terminates on the handshake of addr NUM_REGS-1, so wrap-around never issues a ninth read.
- Back-pressure: rsp_ready low holds RESP indefinitely; the register file is not accessed while stalled.
- cmd_valid/cmd_data changes while not IDLE are ignored.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, dump flag = 0, addr = 0.
  - Outputs: rsp_valid 0, rsp_addr 0, rsp_data 0, rf_read_addr 0, rf_write_addr 0, rf_data_in 0, rf_write_enable 0, busy 0, cmd_ready 1.
- Reset mid-operation aborts the current command immediately:
  - A pending response is dropped.
  - A write in WR not yet clocked is not performed.
  - A dump is abandoned.
- WRITE accepted at edge E0: rf_write_enable high in cycle E0..E1; the register is updated at E1. The next command can be accepted at E2.
- READ accepted at E0:
  - RD_ADDR in E0..E1, RD_WAIT in E1..E2.
  - rsp_valid rises after E2, i.e. 3 edges after acceptance including E0.
  - With rsp_ready held high, the next command can be accepted at E4.
- DUMP with rsp_ready held high: one response every 3 cycles, 8 responses in total; IDLE after the 8th handshake.
- Read after write to the same address is always coherent: the write commits at least 2 edges before the read address is sampled.

## Structure
- Shared package reg_port_pkg holds:
  - ADDR_W, DATA_W, NUM_REGS.
  - Op-code constants OP_NOP, OP_WRITE, OP_READ, OP_DUMP.
  - The state enum.
- Single module, with no sub-module. The testbench instantiates reg_port_master together with Registers.

## Test plan
- Reset with rst_n low mid-DUMP -> all outputs at reset values; cmd_ready 1 on release; no further rsp_valid.
- WRITE addr 5 data 0xA7, then READ addr 5 -> exactly one rf_write_enable pulse; response rsp_addr 5, rsp_data 0xA7, rsp_valid 3 cycles after read acceptance.
- WRITE 0x10+i to each addr i (0..7), then DUMP with rsp_ready high -> 8 responses, addr 0..7, data 0x10..0x17, 3 cycles apart; then busy 0.
- DUMP with rsp_ready toggled randomly -> the same 8 responses in order, each stable while stalled; no lost or duplicate response; no extra file access.
- NOP, and commands presented while busy -> no response, no write, and no acceptance until IDLE.
- WRITE addr 7 data 0xFF, immediately followed by READ addr 7 (accepted at the earliest cycle) -> rsp_data 0xFF.

Source files
------------

// File: rtl/reg_port_pkg.sv
// Shared definitions for the register-file command initiator.
//   ADDR_W / DATA_W / NUM_REGS : register file geometry
//   OP_*                       : cmd_op encodings
//   state_t                    : controller state encoding
package reg_port_pkg;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_DUMP  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ADDR,
    S_RD_WAIT,
    S_RESP
  } state_t;
endpackage

// File: rtl/reg_port_master.sv
// Command-driven initiator for the 8x8 register file.
// Accepts WRITE / READ / DUMP commands one at a time (cmd_valid/cmd_ready),
// drives the file's write and read ports, hides the file's one-cycle
// registered read latency and returns read data on a valid/ready channel.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   cmd_valid/ready, cmd_op/addr/data command channel
//   rsp_valid/ready, rsp_addr/data    response channel
//   rf_read_addr, rf_write_addr,
//   rf_data_in, rf_write_enable       register file inputs
//   rf_data_out                       register file registered read data
//   busy                              controller not idle
module reg_port_master #(
  parameter int ADDR_W   = reg_port_pkg::ADDR_W,
  parameter int DATA_W   = reg_port_pkg::DATA_W,
  parameter int NUM_REGS = reg_port_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rf_read_addr,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              rf_write_enable,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic              busy
);
  import reg_port_pkg::*;

  state_t            state, nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              dump;
  logic              last;
  logic              accept;

  assign accept = (state == S_IDLE) && cmd_valid;
  // The dump ends on the handshake of the top register, so the
  // ADDR_W-bit increment never wraps into a ninth read.
  assign last   = (addr == ADDR_W'(NUM_REGS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_WRITE:         nxt = S_WR;
            OP_READ, OP_DUMP: nxt = S_RD_ADDR;
            default:          nxt = S_IDLE;
          endcase
        end
      end
      S_WR:      nxt = S_IDLE;
      S_RD_ADDR: nxt = S_RD_WAIT;
      S_RD_WAIT: nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) nxt = (!dump || last) ? S_IDLE : S_RD_ADDR;
      end
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      dump     <= 1'b0;
      rsp_addr <= '0;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        case (cmd_op)
          OP_WRITE: begin
            wr_addr <= cmd_addr;
            wr_data <= cmd_data;
          end
          OP_READ: begin
            addr <= cmd_addr;
            dump <= 1'b0;
          end
          OP_DUMP: begin
            addr <= '0;
            dump <= 1'b1;
          end
          default: ;
        endcase
      end
      // rf_data_out now reflects the address sampled at the end of RD_ADDR.
      if (state == S_RD_WAIT) begin
        rsp_addr <= addr;
        rsp_data <= rf_data_out;
      end
      if (state == S_RESP && rsp_ready && dump && !last)
        addr <= addr + ADDR_W'(1);
    end
  end

  assign cmd_ready       = (state == S_IDLE);
  assign busy            = (state != S_IDLE);
  assign rsp_valid       = (state == S_RESP);
  assign rf_write_enable = (state == S_WR);
  assign rf_read_addr    = addr;
  assign rf_write_addr   = wr_addr;
  assign rf_data_in      = wr_data;
endmodule
